// File: rtl/addsub_pkg.sv
// Shared phase and mode encodings for the add/subtract display path.
package addsub_pkg;

  typedef enum logic [1:0] {
    PH_LOAD_A = 2'd0,
    PH_LOAD_B = 2'd1,
    PH_SHOW   = 2'd2
  } phase_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_sequencer_key_debounce.sv
// Pushbutton conditioner: 2-flop sync, stable-count debounce, one-cycle press pulse.
// Pulse is registered DEBOUNCE_CYCLES+2 edges after a clean fall; no backpressure.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // Level flips on the last mismatching cycle; only the falling flip is a press.
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/addsub_sequencer.sv
// Captures operands A and B on successive key presses and registers A+B or A-B.
// Outputs update one edge after the debounced press pulse; no backpressure.
module addsub_sequencer
  import addsub_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             mode_sw,
  input  logic             key_n,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] result,
  output logic             s,
  output logic             carryOut,
  output logic             valid,
  output logic [1:0]       phase
);

  logic           press;
  phase_t         state;
  logic [WIDTH:0] sum;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .press (press)
  );

  // Subtract is A + ~B + 1, so carry out of the top bit means "no borrow".
  always_comb begin
    sum = {1'b0, a_out}
        + {1'b0, (mode_sw == MODE_SUB) ? ~sw : sw}
        + {{WIDTH{1'b0}}, (mode_sw == MODE_SUB)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PH_LOAD_A;
      a_out    <= '0;
      b_out    <= '0;
      result   <= '0;
      s        <= MODE_ADD;
      carryOut <= 1'b0;
      valid    <= 1'b0;
    end else begin
      case (state)
        PH_LOAD_A: if (press) begin
          a_out <= sw;
          state <= PH_LOAD_B;
        end
        PH_LOAD_B: if (press) begin
          b_out              <= sw;
          s                  <= mode_sw;
          {carryOut, result} <= sum;
          valid              <= 1'b1;
          state              <= PH_SHOW;
        end
        PH_SHOW: if (press) begin
          valid <= 1'b0;
          state <= PH_LOAD_A;
        end
        default: begin
          valid <= 1'b0;
          state <= PH_LOAD_A;
        end
      endcase
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_addsub_sequencer.sv
// Directed bench for addsub_sequencer with a queue of expected output snapshots.
module tb_addsub_sequencer;

  localparam int W = 4;
  localparam int N = 4;

  typedef struct {
    int a;
    int b;
    int res;
    int s;
    int c;
    int valid;
    int phase;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw = '0;
  logic         mode_sw = 1'b0;
  logic         key_n = 1'b1;
  logic [W-1:0] a_out, b_out, result;
  logic         s, carryOut, valid;
  logic [1:0]   phase;

  int   checks = 0;
  int   errors = 0;
  exp_t model;
  exp_t sb[$];

  addsub_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .mode_sw(mode_sw), .key_n(key_n),
    .a_out(a_out), .b_out(b_out), .result(result), .s(s),
    .carryOut(carryOut), .valid(valid), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".a_out"}, int'(a_out), e.a);
    chk({tag, ".b_out"}, int'(b_out), e.b);
    chk({tag, ".result"}, int'(result), e.res);
    chk({tag, ".s"}, int'(s), e.s);
    chk({tag, ".carryOut"}, int'(carryOut), e.c);
    chk({tag, ".valid"}, int'(valid), e.valid);
    chk({tag, ".phase"}, int'(phase), e.phase);
  endtask

  function automatic exp_t model_next(input exp_t cur, input int swv, input int mode);
    exp_t n;
    n = cur;
    case (cur.phase)
      0: begin n.a = swv; n.phase = 1; end
      1: begin
        n.b = swv; n.s = mode; n.valid = 1; n.phase = 2;
        if (mode != 0) begin
          n.res = (cur.a - swv + 16) % 16;
          n.c   = (cur.a >= swv) ? 1 : 0;
        end else begin
          n.res = (cur.a + swv) % 16;
          n.c   = (cur.a + swv > 15) ? 1 : 0;
        end
      end
      default: begin n.valid = 0; n.phase = 0; end
    endcase
    return n;
  endfunction

  function automatic exp_t zero_state();
    exp_t z;
    z = '{a: 0, b: 0, res: 0, s: 0, c: 0, valid: 0, phase: 0};
    return z;
  endfunction

  // Press, wait (bounded) for the DUT to move phase, then compare against the queued snapshot.
  task automatic press_expect(input string tag, input int swv, input int mode);
    int   old_ph;
    bit   moved;
    exp_t e;
    sw      = W'(swv);
    mode_sw = mode[0];
    model   = model_next(model, swv, mode);
    sb.push_back(model);
    old_ph  = int'(phase);
    moved   = 1'b0;
    key_n   = 1'b0;
    for (int i = 0; i < 40 && !moved; i++) begin
      @(negedge clk);
      if (int'(phase) != old_ph) moved = 1'b1;
    end
    if (!moved) chk({tag, ".timeout"}, 0, 1);
    e = sb.pop_front();
    check_all(tag, e);
    key_n = 1'b1;
    tick(12);
  endtask

  initial begin
    exp_t e;
    int   prev_ph;
    int   changes;

    // Reset, then idle after release.
    model = zero_state();
    tick(3);
    check_all("reset", model);
    rst_n = 1'b1;
    tick(20);
    check_all("post_reset_idle", model);

    // Add: 9 + 8 wraps to 1 with carry.
    press_expect("add_a", 9, 0);
    press_expect("add_show", 8, 0);
    press_expect("add_back", 0, 0);

    // Subtract with and without borrow.
    press_expect("sub1_a", 3, 0);
    press_expect("sub1_show", 5, 1);
    press_expect("sub1_back", 0, 0);
    press_expect("sub2_a", 7, 0);
    press_expect("sub2_show", 2, 1);
    press_expect("sub2_back", 0, 0);

    // Short bounces must never be accepted.
    sw = 4'hA;
    for (int k = 0; k < 5; k++) begin
      key_n = 1'b0; tick(3);
      key_n = 1'b1; tick(3);
    end
    tick(8);
    check_all("bounce", model);

    // Clean 10-cycle press: phase moves exactly N+3 edges after the fall.
    sw = 4'hC;
    model = model_next(model, 12, 0);
    sb.push_back(model);
    key_n = 1'b0;
    tick(N + 2);
    chk("latency.early_phase", int'(phase), 0);
    tick(1);
    e = sb.pop_front();
    check_all("latency", e);
    tick(10 - (N + 3));
    key_n = 1'b1;
    tick(12);

    press_expect("hold_prep_show", 1, 0);
    press_expect("hold_prep_back", 0, 0);

    // Long hold in LOAD_A produces a single advance.
    sw = 4'h4;
    model = model_next(model, 4, 0);
    sb.push_back(model);
    prev_ph = int'(phase);
    changes = 0;
    key_n = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (int'(phase) != prev_ph) changes++;
      prev_ph = int'(phase);
    end
    chk("hold.advances", changes, 1);
    e = sb.pop_front();
    check_all("hold", e);
    key_n = 1'b1;
    tick(12);
    press_expect("hold_next_show", 2, 0);
    press_expect("hold_next_back", 0, 0);

    // Asynchronous reset in LOAD_B clears the capture immediately.
    press_expect("midrst_a", 6, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.a_out", int'(a_out), 0);
    chk("midrst.phase", int'(phase), 0);
    model = zero_state();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    press_expect("after_rst_a", 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
